seg_mux_display: RTL and testbench

SEG_MUX_DISPLAY -- requirements
Module: seg_mux_display

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 11 +
 rtl/seg_mux_display.sv | 142 ++++++++++++++
 tb/tb_seg_mux_display.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Seven-segment encoding shared by the display multiplexer.
// Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the output registers.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-BCD codes 10..15 render as a dash so corrupt data is visible.
    function automatic logic [6:0] seg7_encode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high seven-segment decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = seg7_encode(i_bcd);

endmodule

// File: rtl/seg_mux_display.sv
// Time-multiplexed seven-segment driver with frame-synchronous (tear-free) value
// updates, leading-zero blanking and selectable common-anode polarity.
module seg_mux_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter bit COMMON_ANODE = 1'b0,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0]         PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_POL   = {7{COMMON_ANODE}};
    localparam logic [NUM_DIGITS-1:0] AN_POL    = {NUM_DIGITS{COMMON_ANODE}};

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_flag;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [6:0]              r_seg;
    logic                    r_dp_out;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_wrap;
    logic [3:0]              w_digit;
    logic [6:0]              w_digit_seg;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [6:0]              w_seg_next;
    logic                    w_dp_next;
    logic [NUM_DIGITS-1:0]   w_an_next;

    assign w_tick = enable && (r_presc == PRESC_MAX);
    assign w_wrap = w_tick && (r_idx == IDX_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (enable) begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // A load coinciding with the wrap still lands in pending, after the old contents move out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_val  <= '0;
            r_pend_dp   <= '0;
            r_pend_flag <= 1'b0;
            r_disp_val  <= '0;
            r_disp_dp   <= '0;
        end else begin
            if (w_wrap && r_pend_flag) begin
                r_disp_val  <= r_pend_val;
                r_disp_dp   <= r_pend_dp;
                r_pend_flag <= 1'b0;
            end
            if (load) begin
                r_pend_val  <= value;
                r_pend_dp   <= dp;
                r_pend_flag <= 1'b1;
            end
        end
    end

    assign w_digit = r_disp_val[{r_idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .i_bcd (w_digit),
        .o_seg (w_digit_seg)
    );

    // A digit blanks while it and everything above it is a zero with no decimal point.
    always_comb begin
        logic zero_run;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_lz_mask = '0;
        zero_run  = LZ_BLANK;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run && (r_disp_val[4*i +: 4] == 4'd0) && !r_disp_dp[i];
            w_lz_mask[i] = zero_run;
        end
    end

    always_comb begin
        w_seg_next = SEG_BLANK;
        w_dp_next  = 1'b0;
        w_an_next  = '0;
        if (enable) begin
            w_an_next = NUM_DIGITS'(1) << r_idx;
            if (!w_lz_mask[r_idx]) begin
                w_seg_next = w_digit_seg;
                w_dp_next  = r_disp_dp[r_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= SEG_POL;
            r_dp_out     <= COMMON_ANODE;
            r_an         <= AN_POL;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_next ^ SEG_POL;
            r_dp_out     <= w_dp_next ^ COMMON_ANODE;
            r_an         <= w_an_next ^ AN_POL;
            r_frame_done <= w_wrap;
        end
    end

    assign seg        = r_seg;
    assign dp_out     = r_dp_out;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_mux_display.sv
// Bench for seg_mux_display: an active-high and a common-anode instance share stimulus
// and are checked every cycle against a cycle-count model of the scan.
module tb_seg_mux_display;

    localparam int N = 4;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        enable;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;
    logic        fd_a, fd_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_mux_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .COMMON_ANODE(1'b0), .LZ_BLANK(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load), .enable(enable),
        .seg(seg_a), .dp_out(dp_a), .an(an_a), .frame_done(fd_a)
    );

    seg_mux_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .COMMON_ANODE(1'b1), .LZ_BLANK(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load), .enable(enable),
        .seg(seg_b), .dp_out(dp_b), .an(an_b), .frame_done(fd_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: digit position follows from the number of enabled cycles since reset.
    logic [6:0]  seg_tab [16];
    logic [15:0] m_val, m_pval;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pflag;
    int          m_cnt;
    logic [11:0] exp_out;
    logic        exp_fd;

    initial begin
        seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
        seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
        seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1101111;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1000000;
    end

    always @(negedge clk) begin
        int idx;
        bit tick, wrap, blank;
        if (!rst_n) begin
            check("reset_a", {seg_a, dp_a, an_a, fd_a}, 32'h0);
            check("reset_b", {seg_b, dp_b, an_b, fd_b}, {19'h0, 12'hFFF, 1'b0});
            m_val = '0; m_pval = '0; m_dp = '0; m_pdp = '0; m_pflag = 1'b0; m_cnt = 0;
            exp_out = '0; exp_fd = 1'b0;
        end else begin
            check("scan_a", {seg_a, dp_a, an_a, fd_a}, {19'h0, exp_out, exp_fd});
            check("scan_b", {seg_b, dp_b, an_b, fd_b}, {19'h0, ~exp_out, exp_fd});
            idx  = (m_cnt / R) % N;
            tick = enable && (m_cnt % R == R - 1);
            wrap = tick && (idx == N - 1);
            if (enable) begin
                blank = 1'b0;
                if (idx != 0) begin
                    blank = 1'b1;
                    for (int j = idx; j < N; j++)
                        if (m_val[4*j +: 4] != 4'd0 || m_dp[j]) blank = 1'b0;
                end
                exp_out = {blank ? 7'b0 : seg_tab[m_val[4*idx +: 4]],
                           blank ? 1'b0 : m_dp[idx], 4'(1 << idx)};
            end else begin
                exp_out = '0;
            end
            exp_fd = wrap;
            if (wrap && m_pflag) begin
                m_val = m_pval; m_dp = m_pdp; m_pflag = 1'b0;
            end
            if (load) begin
                m_pval = value; m_pdp = dp; m_pflag = 1'b1;
            end
            if (enable) m_cnt = (m_cnt + 1) % (R * N);
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(posedge clk); #1;
        value = v; dp = d; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Returns at the negedge where frame_done is high; n = negedges waited.
    task automatic wait_fd(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            n++;
            if (fd_a === 1'b1) break;
        end
        check("fd_seen", fd_a, 1);
    endtask

    // Checks one full scan after the next frame_done; segs = {d3,d2,d1,d0}.
    task automatic show_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        int n;
        wait_fd(n);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k % 4 == 0) begin
                check({tag, "_an"},  an_a,  32'(1 << (k / 4)));
                check({tag, "_seg"}, seg_a, segs[7*(k/4) +: 7]);
                check({tag, "_dp"},  dp_a,  dps[k/4]);
            end
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; value = '0; dp = '0; load = 1'b0; enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg_a", seg_a, 7'b0000000);
        check("rst_an_a",  an_a,  4'b0000);
        check("rst_seg_b", seg_b, 7'b1111111);
        check("rst_an_b",  an_b,  4'b1111);
        rst_n = 1'b1;

        wait_fd(n);
        wait_fd(n);
        check("fd_period", n, 16);

        do_load(16'h1234, 4'b0000);
        show_frame("v1234", {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}, 4'b0000);

        do_load(16'h0050, 4'b0000);
        show_frame("v0050", {7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111}, 4'b0000);

        do_load(16'h0000, 4'b0000);
        show_frame("v0000", {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}, 4'b0000);

        do_load(16'h0007, 4'b0100);
        show_frame("v0007", {7'b0000000, 7'b0111111, 7'b0111111, 7'b0000111}, 4'b0100);

        // Load lands in the wrap-tick cycle: one more frame of the old value first.
        wait_fd(n);
        repeat (15) @(posedge clk);
        #1; value = 16'h00AF; dp = 4'b0000; load = 1'b1;
        @(posedge clk);
        #1; load = 1'b0;
        show_frame("old", {7'b0000000, 7'b0111111, 7'b0111111, 7'b0000111}, 4'b0100);
        show_frame("vAF", {7'b0000000, 7'b0000000, 7'b1000000, 7'b1000000}, 4'b0000);

        do_load(16'h0008, 4'b0000);
        wait_fd(n);
        @(negedge clk);
        check("ca_seg8", seg_b, 7'b0000000);
        check("ca_an",   an_b,  4'b1110);

        // Enable drops at digit 1, prescaler 2, for ten cycles.
        wait_fd(n);
        repeat (6) @(posedge clk);
        #1; enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("dis_an",  an_a,  4'b0000);
        check("dis_seg", seg_a, 7'b0000000);
        check("dis_an_b", an_b, 4'b1111);
        repeat (9) @(posedge clk);
        #1; enable = 1'b1;
        @(negedge clk);
        check("dis_still_an", an_a, 4'b0000);
        @(negedge clk);
        check("resume_an0", an_a, 4'b0010);
        @(negedge clk);
        check("resume_an1", an_a, 4'b0010);
        @(negedge clk);
        check("resume_an2", an_a, 4'b0100);

        // Reset mid-frame discards a pending load.
        do_load(16'h9999, 4'b1111);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg_a", seg_a, 7'b0000000);
        check("arst_an_a",  an_a,  4'b0000);
        check("arst_seg_b", seg_b, 7'b1111111);
        check("arst_an_b",  an_b,  4'b1111);
        check("arst_fd",    fd_a,  0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        show_frame("post_rst", {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}, 4'b0000);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
